// File: rtl/riscv_core_branch_recovery_queue_pkg.sv
// Shared types for the branch recovery queue: queued prediction record, recovery FSM
// states, and the outcome check applied to the oldest record at resolve time.
package riscv_core_pred_pkg;

  localparam int ALEN = 32;

  typedef struct packed {
    logic            branch;
    logic            jump;
    logic            p;        // effective prediction: hit & taken
    logic [ALEN-1:0] pc;
    logic [ALEN-1:0] target;
    logic [ALEN-1:0] pc_next;
  } pred_entry_t;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } recovery_state_e;

  typedef struct packed {
    logic            mispredict;
    logic [ALEN-1:0] recovery;
  } check_result_t;

  function automatic check_result_t check_outcome(input pred_entry_t e,
                                                  input logic taken,
                                                  input logic [ALEN-1:0] addr);
    check_result_t r;
    r.mispredict = 1'b0;
    r.recovery   = addr;
    if (e.jump) begin
      r.mispredict = !(e.p && (e.target == addr));
    end else if (!taken) begin
      // Not taken: wrong only if we predicted taken; redirect to fall-through.
      r.mispredict = e.p;
      r.recovery   = e.pc_next;
    end else begin
      r.mispredict = !(e.p && (e.target == addr));
    end
    return r;
  endfunction

endpackage

// File: rtl/riscv_core_branch_recovery_queue_if.sv
// Fetch/EX/predictor-facing signal bundle of the branch recovery queue.
interface riscv_core_branch_recovery_queue_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  import riscv_core_pred_pkg::*;

  // Push handshake: a record transfers on a cycle where i_push_valid & o_push_ready
  // are both high at the clock edge; o_push_ready never depends on i_push_valid.
  logic                    i_push_valid;
  logic                    o_push_ready;
  logic                    i_push_branch;
  logic                    i_push_jump;
  logic                    i_push_hit;
  logic                    i_push_taken;
  logic [ALEN-1:0]         i_push_pc;
  logic [ALEN-1:0]         i_push_target;
  logic [ALEN-1:0]         i_push_pc_next;
  logic                    i_res_valid;
  logic                    i_res_taken;
  logic [ALEN-1:0]         i_res_address;
  logic                    o_mis_prediction;
  logic [ALEN-1:0]         o_recovery_address;
  logic                    o_upd_valid;
  logic [ALEN-1:0]         o_upd_pc;
  logic [ALEN-1:0]         o_upd_target;
  logic                    o_upd_taken;
  logic                    o_res_error;
  logic [$clog2(DEPTH):0]  o_count;
  logic [CNT_W-1:0]        o_cnt_resolved;
  logic [CNT_W-1:0]        o_cnt_mispred;
  recovery_state_e         o_dbg_state;

  modport slave (
    input  i_push_valid, i_push_branch, i_push_jump, i_push_hit, i_push_taken,
           i_push_pc, i_push_target, i_push_pc_next, i_res_valid, i_res_taken, i_res_address,
    output o_push_ready, o_mis_prediction, o_recovery_address, o_upd_valid, o_upd_pc,
           o_upd_target, o_upd_taken, o_res_error, o_count, o_cnt_resolved, o_cnt_mispred,
           o_dbg_state
  );

  modport master (
    output i_push_valid, i_push_branch, i_push_jump, i_push_hit, i_push_taken,
           i_push_pc, i_push_target, i_push_pc_next, i_res_valid, i_res_taken, i_res_address,
    input  o_push_ready, o_mis_prediction, o_recovery_address, o_upd_valid, o_upd_pc,
           o_upd_target, o_upd_taken, o_res_error, o_count, o_cnt_resolved, o_cnt_mispred,
           o_dbg_state
  );

endinterface

// File: rtl/riscv_core_branch_recovery_queue_fifo.sv
// In-order storage for prediction records with push/pop/clear and occupancy flags.
module riscv_core_pred_fifo
  import riscv_core_pred_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   push,
  input  pred_entry_t            push_data,
  input  logic                   pop,
  input  logic                   clear,
  output pred_entry_t            head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  pred_entry_t   mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  // Callers only push when !full and pop when !empty; clear wins over both.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/riscv_core_branch_recovery_queue.sv
// Branch recovery queue: checks the oldest in-flight prediction against the EX outcome,
// raises a registered flush with recovery PC, and feeds predictor updates and counters.
module riscv_core_branch_recovery_queue
  import riscv_core_pred_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input logic                               i_clk,
  input logic                               i_rst,
  riscv_core_branch_recovery_queue_if.slave bus
);

  recovery_state_e        state_q, state_d;
  pred_entry_t            push_entry, head;
  logic                   full, empty;
  logic [$clog2(DEPTH):0] count;
  logic                   push_ready, push_fire, res_fire, res_err, flush;
  check_result_t          chk;

  logic                   mis_q, upd_valid_q, upd_taken_q, err_q;
  logic [ALEN-1:0]        rec_q, upd_pc_q, upd_target_q;
  logic [CNT_W-1:0]       cnt_res_q, cnt_mis_q;

  assign push_ready = (state_q == RUN) && !full;
  // Records that are neither or both branch and jump are malformed and dropped.
  assign push_fire  = bus.i_push_valid && push_ready && (bus.i_push_branch ^ bus.i_push_jump);
  assign res_fire   = bus.i_res_valid && !empty && (state_q == RUN);
  assign res_err    = bus.i_res_valid &&  empty && (state_q == RUN);

  always_comb begin
    push_entry         = '0;
    push_entry.branch  = bus.i_push_branch;
    push_entry.jump    = bus.i_push_jump;
    push_entry.p       = bus.i_push_hit & bus.i_push_taken;
    push_entry.pc      = bus.i_push_pc;
    push_entry.target  = bus.i_push_target;
    push_entry.pc_next = bus.i_push_pc_next;
  end

  always_comb begin
    chk   = check_outcome(head, bus.i_res_taken, bus.i_res_address);
    flush = res_fire && chk.mispredict;
  end

  riscv_core_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .push      (push_fire),
    .push_data (push_entry),
    .pop       (res_fire),
    .clear     (flush),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= RUN;
    else       state_q <= state_d;
  end

  // RECOVER lasts exactly the one cycle in which the flush pulse is visible.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (flush) state_d = RECOVER;
      RECOVER: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mis_q        <= 1'b0;
      rec_q        <= '0;
      upd_valid_q  <= 1'b0;
      upd_pc_q     <= '0;
      upd_target_q <= '0;
      upd_taken_q  <= 1'b0;
      err_q        <= 1'b0;
      cnt_res_q    <= '0;
      cnt_mis_q    <= '0;
    end else begin
      mis_q        <= flush;
      rec_q        <= flush ? chk.recovery : '0;
      upd_valid_q  <= res_fire;
      upd_pc_q     <= res_fire ? head.pc : '0;
      upd_target_q <= res_fire ? bus.i_res_address : '0;
      upd_taken_q  <= res_fire && (bus.i_res_taken || head.jump);
      err_q        <= res_err;
      if (res_fire && (cnt_res_q != {CNT_W{1'b1}})) cnt_res_q <= cnt_res_q + 1'b1;
      if (flush    && (cnt_mis_q != {CNT_W{1'b1}})) cnt_mis_q <= cnt_mis_q + 1'b1;
    end
  end

  assign bus.o_push_ready       = push_ready;
  assign bus.o_mis_prediction   = mis_q;
  assign bus.o_recovery_address = rec_q;
  assign bus.o_upd_valid        = upd_valid_q;
  assign bus.o_upd_pc           = upd_pc_q;
  assign bus.o_upd_target       = upd_target_q;
  assign bus.o_upd_taken        = upd_taken_q;
  assign bus.o_res_error        = err_q;
  assign bus.o_count            = count;
  assign bus.o_cnt_resolved     = cnt_res_q;
  assign bus.o_cnt_mispred      = cnt_mis_q;
  assign bus.o_dbg_state        = state_q;

endmodule

// File: tb/tb_riscv_core_branch_recovery_queue.sv
// Randomized scoreboard bench for the branch recovery queue against a queue-based model.
module tb_riscv_core_branch_recovery_queue;
  import riscv_core_pred_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  riscv_core_branch_recovery_queue_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  riscv_core_branch_recovery_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Reference model: list of outstanding predictions plus a recover flag.
  typedef struct {
    bit          jump;
    bit          p;
    logic [31:0] pc;
    logic [31:0] target;
    logic [31:0] pc_next;
  } rec_t;

  typedef struct packed {
    logic [31:0] due;
    logic        err;
    logic        mis;
    logic        taken;
    logic [31:0] rec;
    logic [31:0] pc;
    logic [31:0] tgt;
  } exp_t;
  localparam int EW = $bits(exp_t);

  rec_t            mq[$];
  logic [EW-1:0]   exp_q[$];
  bit              m_recover = 0;
  int              m_res = 0;
  int              m_mis = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle();
    bus.i_push_valid = 0; bus.i_push_branch = 0; bus.i_push_jump = 0;
    bus.i_push_hit = 0; bus.i_push_taken = 0; bus.i_push_pc = '0;
    bus.i_push_target = '0; bus.i_push_pc_next = '0;
    bus.i_res_valid = 0; bus.i_res_taken = 0; bus.i_res_address = '0;
  endtask

  // One cycle: check model-visible state, drive inputs, advance the model to the next edge.
  task automatic drive_cycle(input bit pv, input bit br, input bit jp, input bit hit,
                             input bit tk, input logic [31:0] pc, input logic [31:0] tgt,
                             input logic [31:0] pcn, input bit rv, input bit rt,
                             input logic [31:0] ra);
    bit   ready, push_acc, flush, t_eff;
    rec_t h, n;
    exp_t e;
    @(negedge clk);
    check("count", 64'(bus.o_count), 64'(mq.size()));
    check("push_ready", 64'(bus.o_push_ready), 64'(!m_recover && mq.size() < DEPTH));
    check("cnt_resolved", 64'(bus.o_cnt_resolved), 64'(m_res));
    check("cnt_mispred", 64'(bus.o_cnt_mispred), 64'(m_mis));
    bus.i_push_valid = pv; bus.i_push_branch = br; bus.i_push_jump = jp;
    bus.i_push_hit = hit; bus.i_push_taken = tk; bus.i_push_pc = pc;
    bus.i_push_target = tgt; bus.i_push_pc_next = pcn;
    bus.i_res_valid = rv; bus.i_res_taken = rt; bus.i_res_address = ra;
    ready    = !m_recover && mq.size() < DEPTH;
    push_acc = pv && ready && (br != jp);
    flush    = 0;
    e        = '0;
    e.due    = 32'(cyc + 1);
    if (rv && !m_recover) begin
      if (mq.size() == 0) begin
        e.err = 1;
        exp_q.push_back(e);
      end else begin
        h       = mq.pop_front();
        t_eff   = rt || h.jump;
        e.mis   = (h.p != t_eff) || (h.p && t_eff && h.target != ra);
        e.rec   = e.mis ? (t_eff ? ra : h.pc_next) : 32'h0;
        e.pc    = h.pc;
        e.tgt   = ra;
        e.taken = t_eff;
        exp_q.push_back(e);
        m_res   = (m_res < CMAX) ? m_res + 1 : CMAX;
        if (e.mis) m_mis = (m_mis < CMAX) ? m_mis + 1 : CMAX;
        flush = e.mis;
      end
    end
    if (push_acc) begin
      n.jump = jp; n.p = hit && tk; n.pc = pc; n.target = tgt; n.pc_next = pcn;
      mq.push_back(n);
    end
    if (flush) mq.delete();
    m_recover = flush;
  endtask

  // Monitor: pops an expectation whenever the DUT presents an update or error pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.o_upd_valid || bus.o_res_error) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: upd_valid=%0b res_error=%0b with nothing expected",
                   bus.o_upd_valid, bus.o_res_error);
        end else begin
          e = exp_q.pop_front();
          check("out_timing", 64'(cyc), 64'(e.due));
          check("res_error", 64'(bus.o_res_error), 64'(e.err));
          check("upd_valid", 64'(bus.o_upd_valid), 64'(!e.err));
          check("mis_prediction", 64'(bus.o_mis_prediction), 64'(e.mis));
          check("recovery_address", 64'(bus.o_recovery_address), 64'(e.rec));
          check("upd_pc", 64'(bus.o_upd_pc), 64'(e.pc));
          check("upd_target", 64'(bus.o_upd_target), 64'(e.tgt));
          check("upd_taken", 64'(bus.o_upd_taken), 64'(e.taken));
        end
      end else begin
        check("idle_mis_taken", {62'h0, bus.o_mis_prediction, bus.o_upd_taken}, 64'h0);
        check("idle_addr", {bus.o_recovery_address, bus.o_upd_pc}, 64'h0);
        if (exp_q.size() > 0) begin
          e = exp_q[0];
          if (e.due <= 32'(cyc)) begin
            checks++; errors++;
            $display("FAIL missed_output: nothing presented, expected due at cycle %0d", e.due);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] ra, tgt;
    bit          rt, br, jp;
    int          k;
    idle();
    #2;
    check("rst_count", 64'(bus.o_count), 64'h0);
    check("rst_push_ready", 64'(bus.o_push_ready), 64'h1);
    check("rst_mis", 64'(bus.o_mis_prediction), 64'h0);
    check("rst_cnts", {bus.o_cnt_resolved, bus.o_cnt_mispred}, 64'h0);
    repeat (2) @(negedge clk);
    rst = 0;

    // Correct not-taken branch.
    drive_cycle(1, 1, 0, 0, 0, 32'h80, 32'h100, 32'h84, 0, 0, 32'h0);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h84);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    // Predicted taken, actually not taken: recover to fall-through 0x84.
    drive_cycle(1, 1, 0, 1, 1, 32'h80, 32'h100, 32'h84, 0, 0, 32'h0);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h90);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    // Jump with wrong target and three younger records, then a resolve during RECOVER.
    drive_cycle(1, 0, 1, 1, 1, 32'h1f0, 32'h200, 32'h1f4, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++)
      drive_cycle(1, 1, 0, 0, 0, 32'h300 + 32'(i * 4), 32'h400, 32'h304 + 32'(i * 4), 0, 0, 32'h0);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h204);
    drive_cycle(1, 1, 0, 0, 0, 32'h500, 32'h600, 32'h504, 1, 0, 32'h504);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    // Fill to DEPTH, then resolve-ok + push in the same cycle: push refused.
    for (int i = 0; i < DEPTH; i++)
      drive_cycle(1, 1, 0, 0, 0, 32'h700 + 32'(i * 4), 32'h800, 32'h704 + 32'(i * 4), 0, 0, 32'h0);
    drive_cycle(1, 1, 0, 0, 0, 32'h900, 32'h800, 32'h904, 1, 0, 32'h704);
    // Malformed push and drain, then resolve with empty queue.
    drive_cycle(1, 1, 1, 0, 0, 32'ha00, 32'h0, 32'ha04, 1, 0, 32'h708);
    for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h70c + 32'(i * 4));
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);

    // Randomized phase; counters saturate at CMAX along the way.
    for (int i = 0; i < 1500; i++) begin
      k  = $urandom_range(0, 9);
      br = (k < 6) || (k == 9);
      jp = (k >= 6);
      tgt = 32'h1000 + 32'($urandom_range(0, 3) * 16);
      ra  = (mq.size() > 0 && $urandom_range(0, 2) != 0) ? mq[0].target
                                                         : 32'h1000 + 32'($urandom_range(0, 3) * 16);
      rt  = (mq.size() > 0 && mq[0].jump) ? 1'b1 : 1'($urandom_range(0, 1));
      drive_cycle(1'($urandom_range(0, 9) < 7), br, jp, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023) * 4), tgt,
                  32'($urandom_range(0, 1023) * 4 + 4), 1'($urandom_range(0, 9) < 4), rt, ra);
    end

    // Drain with correct resolves, then reset during a mispredicting resolve with 3 entries.
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    for (int n = 0; n < 8 && mq.size() > 0; n++)
      drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, mq[0].jump | mq[0].p, mq[0].target);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    drive_cycle(1, 1, 0, 1, 1, 32'hb00, 32'hc00, 32'hb04, 0, 0, 32'h0);
    drive_cycle(1, 1, 0, 0, 0, 32'hb04, 32'hc00, 32'hb08, 0, 0, 32'h0);
    drive_cycle(1, 0, 1, 1, 1, 32'hb08, 32'hd00, 32'hb0c, 0, 0, 32'h0);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hc00);
    #1;
    check("pre_rst_count", 64'(bus.o_count), 64'h3);
    rst = 1;
    #1;
    check("mid_rst_count", 64'(bus.o_count), 64'h0);
    check("mid_rst_pulses", {60'h0, bus.o_mis_prediction, bus.o_upd_valid, bus.o_res_error,
                             bus.o_upd_taken}, 64'h0);
    check("mid_rst_addr", {bus.o_recovery_address, bus.o_upd_pc}, 64'h0);
    check("mid_rst_cnts", {bus.o_cnt_resolved, bus.o_cnt_mispred}, 64'h0);
    exp_q.delete(); mq.delete(); m_recover = 0; m_res = 0; m_mis = 0;
    idle();
    @(negedge clk);
    rst = 0;
    drive_cycle(1, 1, 0, 0, 0, 32'he00, 32'hf00, 32'he04, 0, 0, 32'h0);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'he04);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
